// File: rtl/addr_pool_pkg.sv
// Shared types and defaults for the SRAM address-pool manager.
package addr_pool_pkg;

    typedef enum logic [2:0] {
        ST_SCAN = 3'b001,
        ST_HOLD = 3'b010,
        ST_FULL = 3'b100
    } state_t;

    localparam int DEF_DEPTH  = 512;
    localparam int DEF_SCAN_W = 32;

    // Chunk index is addr[AW-1:chunk_lsb(SCAN_W)]; the low bits index within a chunk.
    function automatic int chunk_lsb(input int scan_w);
        return $clog2(scan_w);
    endfunction

endpackage

// File: rtl/addr_pool_mgr_if.sv
// Allocation handshake, free port and pool status between the manager and its clients.
interface addr_pool_mgr_if
    import addr_pool_pkg::*;
#(
    parameter int AW = $clog2(DEF_DEPTH)
);
    logic          alloc_vld;
    logic          alloc_rdy;
    logic [AW-1:0] alloc_addr;
    logic          free_vld;
    logic [AW-1:0] free_addr;
    logic          free_err;
    logic [AW:0]   idle_cnt;
    logic          full;

    modport slave (
        output alloc_vld, alloc_addr, free_err, idle_cnt, full,
        input  alloc_rdy, free_vld, free_addr
    );

    modport master (
        input  alloc_vld, alloc_addr, free_err, idle_cnt, full,
        output alloc_rdy, free_vld, free_addr
    );
endinterface

// File: rtl/addr_pool_mgr_chunk_ffs.sv
// Combinational lowest-zero finder over one bitmap chunk.
module chunk_ffs #(
    parameter int SCAN_W = 32,
    parameter int IW     = $clog2(SCAN_W)
) (
    input  logic [SCAN_W-1:0] bits,
    output logic              found,
    output logic [IW-1:0]     idx
);
    // Descending walk so the lowest free bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = SCAN_W - 1; i >= 0; i--) begin
            if (!bits[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end
endmodule

// File: rtl/addr_pool_mgr.sv
// Address-pool manager: used/free bitmap with chunked next-fit prefetch and checked frees.
//   state | meaning
//   SCAN  | examine the chunk holding ptr for a free slot, else step to next chunk
//   HOLD  | alloc_addr offered with alloc_vld high, waiting for alloc_rdy
//   FULL  | no free slot; the next valid free is offered directly
module addr_pool_mgr
    import addr_pool_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SCAN_W = DEF_SCAN_W
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    addr_pool_mgr_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = chunk_lsb(SCAN_W);

    logic [DEPTH-1:0]  map;
    state_t            state, state_nxt;
    logic [AW-1:0]     ptr, ptr_nxt;
    logic [AW-1:0]     addr_q, addr_nxt;
    logic              vld_q, vld_nxt;
    logic              err_q, full_q;
    logic [AW:0]       idle_q, idle_nxt;
    logic [AW-1:0]     chunk_base;
    logic [SCAN_W-1:0] chunk;
    logic              hit;
    logic [CW-1:0]     hit_idx;
    logic              acc, free_bad, free_ok;

    assign chunk_base = ptr & ~AW'(SCAN_W - 1);
    assign chunk      = map[chunk_base +: SCAN_W];

    chunk_ffs #(.SCAN_W(SCAN_W), .IW(CW)) u_ffs (
        .bits  (chunk),
        .found (hit),
        .idx   (hit_idx)
    );

    // The offered slot is still 0 in the map, so freeing it is caught as a double free.
    assign acc      = vld_q & bus.alloc_rdy;
    assign free_bad = !map[bus.free_addr] || (vld_q && (bus.free_addr == addr_q));
    assign free_ok  = bus.free_vld && !free_bad;
    assign idle_nxt = idle_q + (AW+1)'(free_ok) - (AW+1)'(acc);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        addr_nxt  = addr_q;
        vld_nxt   = vld_q;
        case (state)
            ST_SCAN: begin
                if (idle_q == '0) begin
                    state_nxt = ST_FULL;
                end else if (hit) begin
                    addr_nxt  = chunk_base | AW'(hit_idx);
                    vld_nxt   = 1'b1;
                    state_nxt = ST_HOLD;
                end else begin
                    ptr_nxt   = chunk_base + AW'(SCAN_W);
                end
            end
            ST_HOLD: begin
                if (acc) begin
                    vld_nxt   = 1'b0;
                    ptr_nxt   = addr_q + AW'(1);
                    state_nxt = ST_SCAN;
                end
            end
            ST_FULL: begin
                // A free landing while we were entering FULL leaves idle_q nonzero: rescan.
                if (free_ok) begin
                    addr_nxt  = bus.free_addr;
                    vld_nxt   = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (idle_q != '0) begin
                    state_nxt = ST_SCAN;
                end
            end
            default: begin
                vld_nxt   = 1'b0;
                state_nxt = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= ST_SCAN;
            map    <= '0;
            ptr    <= '0;
            addr_q <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            idle_q <= (AW+1)'(DEPTH);
            full_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            addr_q <= addr_nxt;
            vld_q  <= vld_nxt;
            if (acc)     map[addr_q]        <= 1'b1;
            if (free_ok) map[bus.free_addr] <= 1'b0;
            err_q  <= bus.free_vld && free_bad;
            idle_q <= idle_nxt;
            full_q <= (idle_nxt == '0);
        end
    end

    assign bus.alloc_vld  = vld_q;
    assign bus.alloc_addr = addr_q;
    assign bus.free_err   = err_q;
    assign bus.idle_cnt   = idle_q;
    assign bus.full       = full_q;
endmodule

// File: tb/tb_addr_pool_mgr.sv
// Self-checking bench for addr_pool_mgr against a slot-array next-fit reference model.
module tb_addr_pool_mgr;
    import addr_pool_pkg::*;

    localparam int DEPTH  = 512;
    localparam int SCAN_W = 32;
    localparam int AW     = 9;
    localparam int NCHUNK = DEPTH / SCAN_W;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    addr_pool_mgr_if #(.AW(AW)) bus ();

    addr_pool_mgr #(.DEPTH(DEPTH), .SCAN_W(SCAN_W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: slot usage, next-fit pointer, free count, and the slot on offer (-1 none).
    bit used [DEPTH];
    int mptr;
    int midle;
    int m_offer;

    function automatic int model_next();
        for (int c = 0; c < NCHUNK; c++) begin
            int ch;
            ch = ((mptr / SCAN_W) + c) % NCHUNK;
            for (int b = 0; b < SCAN_W; b++)
                if (!used[ch * SCAN_W + b]) return ch * SCAN_W + b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) used[i] = 1'b0;
        mptr    = 0;
        midle   = DEPTH;
        m_offer = 0;
    endtask

    task automatic apply_reset();
        sys_rst       = 1'b1;
        bus.alloc_rdy = 1'b0;
        bus.free_vld  = 1'b0;
        bus.free_addr = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic model_accept();
        used[m_offer] = 1'b1;
        mptr          = (m_offer + 1) % DEPTH;
        midle--;
        m_offer       = (midle > 0) ? model_next() : -1;
    endtask

    task automatic wait_vld();
        int n;
        n = 0;
        while (bus.alloc_vld !== 1'b1 && n < 64) begin
            @(negedge sys_clk);
            n++;
        end
        vectors++;
        if (bus.alloc_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL grant_timeout: alloc_vld=%b after %0d cycles, required 1", bus.alloc_vld, n);
        end
    endtask

    task automatic do_alloc(output int got);
        logic [AW-1:0] exp_addr;
        wait_vld();
        got      = int'(bus.alloc_addr);
        exp_addr = AW'(m_offer);
        vectors++;
        if (bus.alloc_addr !== exp_addr) begin
            miscompares++;
            $display("FAIL grant_addr: got %0d, required %0d", bus.alloc_addr, exp_addr);
        end
        bus.alloc_rdy = 1'b1;
        @(negedge sys_clk);
        bus.alloc_rdy = 1'b0;
        model_accept();
        vectors++;
        if (bus.idle_cnt !== (AW+1)'(midle) || bus.alloc_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL post_accept: idle_cnt=%0d vld=%b, required idle_cnt=%0d vld=0",
                     bus.idle_cnt, bus.alloc_vld, midle);
        end
    endtask

    task automatic do_free(input int a);
        bit exp_err, bypass;
        exp_err = !used[a] || (m_offer == a);
        bypass  = !exp_err && (midle == 0);
        bus.free_vld  = 1'b1;
        bus.free_addr = AW'(a);
        @(negedge sys_clk);
        bus.free_vld  = 1'b0;
        if (!exp_err) begin
            used[a] = 1'b0;
            midle++;
        end
        if (bypass) m_offer = a;
        vectors++;
        if (bus.free_err !== exp_err) begin
            miscompares++;
            $display("FAIL free_err addr=%0d: got %b, required %b", a, bus.free_err, exp_err);
        end
        vectors++;
        if (bus.idle_cnt !== (AW+1)'(midle)) begin
            miscompares++;
            $display("FAIL free_idle addr=%0d: got %0d, required %0d", a, bus.idle_cnt, midle);
        end
        if (bypass) begin
            vectors++;
            if (bus.alloc_vld !== 1'b1 || bus.alloc_addr !== AW'(a)) begin
                miscompares++;
                $display("FAIL full_bypass: vld=%b addr=%0d, required vld=1 addr=%0d",
                         bus.alloc_vld, bus.alloc_addr, a);
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        bus.alloc_rdy = 1'b0;
        bus.free_vld  = 1'b0;
        bus.free_addr = '0;
        repeat (2) @(negedge sys_clk);
        vectors++;
        if ({bus.alloc_vld, bus.alloc_addr, bus.free_err, bus.full, bus.idle_cnt} !==
            {1'b0, AW'(0), 1'b0, 1'b0, (AW+1)'(DEPTH)}) begin
            miscompares++;
            $display("FAIL reset_values: vld=%b addr=%0d err=%b full=%b idle=%0d, required 0 0 0 0 %0d",
                     bus.alloc_vld, bus.alloc_addr, bus.free_err, bus.full, bus.idle_cnt, DEPTH);
        end
        sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        vectors++;
        if (bus.alloc_vld !== 1'b1 || bus.alloc_addr !== AW'(0)) begin
            miscompares++;
            $display("FAIL first_grant: vld=%b addr=%0d, required vld=1 addr=0", bus.alloc_vld, bus.alloc_addr);
        end
    endtask

    task automatic test_fill();
        int got;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_alloc(got);
            if (got != i) begin
                vectors++;
                miscompares++;
                $display("FAIL fill_order: grant %0d got %0d, required %0d", i, got, i);
            end
        end
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (bus.full !== 1'b1 || bus.alloc_vld !== 1'b0 || bus.idle_cnt !== '0) begin
            miscompares++;
            $display("FAIL fill_full: full=%b vld=%b idle=%0d, required 1 0 0", bus.full, bus.alloc_vld, bus.idle_cnt);
        end
    endtask

    task automatic test_full_bypass();
        int got;
        do_free(300);
        do_alloc(got);
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (bus.full !== 1'b1 || got != 300) begin
            miscompares++;
            $display("FAIL refull: full=%b granted=%0d, required full=1 granted=300", bus.full, got);
        end
    endtask

    task automatic test_next_fit();
        int got, n;
        apply_reset();
        for (int i = 0; i < 100; i++) do_alloc(got);
        wait_vld();
        do_free(40);
        n   = 0;
        got = -1;
        while (got != 40 && n < 500) begin
            do_alloc(got);
            n++;
        end
        vectors++;
        if (got != 40 || n != 413) begin
            miscompares++;
            $display("FAIL next_fit_wrap: slot 40 granted at position %0d (last=%0d), required 413", n, got);
        end
    endtask

    task automatic test_double_free();
        int got;
        apply_reset();
        for (int i = 0; i < 10; i++) do_alloc(got);
        wait_vld();
        do_free(7);
        do_free(7);
        do_free(10);
    endtask

    task automatic test_same_cycle();
        int got;
        apply_reset();
        for (int i = 0; i < 5; i++) do_alloc(got);
        wait_vld();
        bus.alloc_rdy = 1'b1;
        bus.free_vld  = 1'b1;
        bus.free_addr = AW'(3);
        @(negedge sys_clk);
        bus.alloc_rdy = 1'b0;
        bus.free_vld  = 1'b0;
        used[3] = 1'b0;
        midle++;
        model_accept();
        vectors++;
        if (bus.free_err !== 1'b0 || bus.idle_cnt !== (AW+1)'(507) ||
            dut.map[5] !== 1'b1 || dut.map[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL acc5_free3: err=%b idle=%0d bit5=%b bit3=%b, required 0 507 1 0",
                     bus.free_err, bus.idle_cnt, dut.map[5], dut.map[3]);
        end
        do_alloc(got);

        apply_reset();
        for (int i = 0; i < 5; i++) do_alloc(got);
        wait_vld();
        bus.alloc_rdy = 1'b1;
        bus.free_vld  = 1'b1;
        bus.free_addr = AW'(5);
        @(negedge sys_clk);
        bus.alloc_rdy = 1'b0;
        bus.free_vld  = 1'b0;
        model_accept();
        vectors++;
        if (bus.free_err !== 1'b1 || bus.idle_cnt !== (AW+1)'(506) || dut.map[5] !== 1'b1) begin
            miscompares++;
            $display("FAIL acc5_free5: err=%b idle=%0d bit5=%b, required 1 506 1",
                     bus.free_err, bus.idle_cnt, dut.map[5]);
        end
        do_alloc(got);
    endtask

    task automatic test_reset_mid();
        int got;
        apply_reset();
        for (int i = 0; i < 200; i++) do_alloc(got);
        sys_rst = 1'b1;
        #1;
        vectors++;
        if ({bus.alloc_vld, bus.alloc_addr, bus.free_err, bus.full, bus.idle_cnt} !==
            {1'b0, AW'(0), 1'b0, 1'b0, (AW+1)'(DEPTH)}) begin
            miscompares++;
            $display("FAIL mid_reset: vld=%b addr=%0d err=%b full=%b idle=%0d, required 0 0 0 0 %0d",
                     bus.alloc_vld, bus.alloc_addr, bus.free_err, bus.full, bus.idle_cnt, DEPTH);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        vectors++;
        if (bus.alloc_vld !== 1'b1 || bus.alloc_addr !== AW'(0)) begin
            miscompares++;
            $display("FAIL regrant: vld=%b addr=%0d, required vld=1 addr=0", bus.alloc_vld, bus.alloc_addr);
        end
        do_alloc(got);
    endtask

    task automatic test_random();
        int got, a, r, start;
        apply_reset();
        for (int op = 0; op < 900; op++) begin
            if (midle == 0) begin
                repeat (2) @(negedge sys_clk);
                vectors++;
                if (bus.full !== 1'b1 || bus.alloc_vld !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_full: full=%b vld=%b, required 1 0", bus.full, bus.alloc_vld);
                end
                do_free(int'($urandom_range(0, DEPTH - 1)));
            end else begin
                wait_vld();
                if ($urandom_range(0, 99) < 80) begin
                    do_alloc(got);
                end else begin
                    r     = int'($urandom_range(0, 9));
                    start = int'($urandom_range(0, DEPTH - 1));
                    a     = start;
                    if (r < 7) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (used[(start + k) % DEPTH]) begin
                                a = (start + k) % DEPTH;
                                break;
                            end
                        end
                    end else if (r == 7) begin
                        a = m_offer;
                    end
                    do_free(a);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_full_bypass();
        test_next_fit();
        test_double_free();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/addr_pool_mgr.md
# addr_pool_mgr

Parametrised SRAM address-pool manager: successor to the 512-entry bitmap recycler, generalised in depth and scan width. Keeps a used/free bitmap of `DEPTH` SRAM slots and prefetches the next free address with a chunked next-fit scan. Hands that address out over a valid/ready handshake and accepts single-address frees with double-free detection. Sits between the packet write controller (allocations) and the read/dequeue controller (frees) in front of the shared packet SRAM.

## Interface
- `DEPTH`, 512, number of SRAM slots; power of two, ≥ `SCAN_W`
- `SCAN_W`, 32, bitmap bits examined per scan cycle; power of two, divides `DEPTH`
- `AW`, $clog2(DEPTH), address width (derived)

- `sys_clk`  in  1  sole clock, rising edge
- `sys_rst`  in  1  reset, asynchronous and active-high
- `alloc_vld`  out  1  `alloc_addr` holds a free slot
- `alloc_rdy`  in  1  consumer takes `alloc_addr` when `alloc_vld` is high
- `alloc_addr`  out  AW  prefetched free slot
- `free_vld`  in  1  return slot `free_addr` to the pool
- `free_addr`  in  AW  slot being returned
- `free_err`  out  1  one-cycle pulse: freed slot was already free; map unchanged
- `idle_cnt`  out  AW+1  number of free slots, including the prefetched one
- `full`  out  1  no free slot exists (`idle_cnt == 0`)

## Operation
- Reset values: bitmap all 0 (free), `idle_cnt = DEPTH`, `alloc_vld = 0`, `alloc_addr = 0`, `free_err = 0`, `full = 0`, scan pointer 0, state SCAN.
- States: SCAN, HOLD, FULL. All outputs are registered.
- SCAN
  - Examines the bitmap chunk that contains the scan pointer: `SCAN_W` aligned bits, read from the registered map.
  - If the chunk has a 0 bit, load the lowest such index into `alloc_addr`, set `alloc_vld`, and go to HOLD.
  - Otherwise advance the pointer to the next chunk, wrapping `DEPTH-1` → 0.
  - If `idle_cnt == 0`, go to FULL instead of scanning.
- HOLD
  - `alloc_vld = 1`.
  - On `alloc_vld && alloc_rdy`: set the bitmap bit, decrement `idle_cnt`, drop `alloc_vld`, set pointer = (`alloc_addr` + 1) mod `DEPTH`, go to SCAN.
- FULL
  - `alloc_vld = 0`.
  - On a valid free: bypass the scan. Load `free_addr` into `alloc_addr` with `alloc_vld = 1` and go to HOLD. The bitmap bit stays 0.
- Free, any state
  - Bitmap bit is 1: clear it and increment `idle_cnt`.
  - Bitmap bit is 0, or it equals the prefetched `alloc_addr` while `alloc_vld` is high: pulse `free_err`; bitmap and count are unchanged.
- Same-cycle alloc accept and valid free: both are applied and `idle_cnt` is unchanged.
- Same-cycle alloc accept and free of that same address: the alloc succeeds and the free is flagged `free_err`.
- A free that lands in a chunk already passed by the scan is found on a later wrap. A scan with `idle_cnt > 0` always terminates.

## Timing
- First grant after reset: `alloc_vld = 1` with `alloc_addr = 0` on the 1st rising edge after reset deasserts.
- Accept at edge N → `alloc_vld` is low in cycle N+1. A hit in that cycle's chunk gives `alloc_vld` high from edge N+2. Minimum grant spacing is 2 cycles.
- Worst-case scan is `DEPTH/SCAN_W` cycles.
- `free_err`, `idle_cnt` and `full` update 1 cycle after the free or accept edge.
- FULL fast path: free at edge N → `alloc_vld` high from edge N+1.
- Asserting `sys_rst` mid-scan or mid-HOLD immediately restores all reset values; a pending grant is discarded.

## Structure
- Shared package `addr_pool_pkg` holds:
  - the state encoding, one-hot, 3 bits: SCAN, HOLD, FULL;
  - the default `DEPTH` and `SCAN_W`;
  - a `chunk index = addr[AW-1:$clog2(SCAN_W)]` helper constant.
- One sub-module, `chunk_ffs`: combinational lowest-zero finder, `SCAN_W` in → found flag plus a $clog2(SCAN_W) index.
- Bitmap is a flop array of `DEPTH` bits; the chunk is selected with an indexed part-select.

## Test plan
- Reset, hold `alloc_rdy = 1` for 512 grants (`DEPTH` 512, `SCAN_W` 32) → addresses 0..511 in order, `idle_cnt` reaches 0, `full = 1`, `alloc_vld = 0`.
- From full, free 300 → `alloc_addr = 300` with `alloc_vld` high the next cycle; accept it → `full` returns to 1.
- Allocate 0..99, free 40, keep allocating → next-fit order 100, 101, … and 40 is not granted until the pointer wraps past 511.
- Free address 7 twice → first free raises `idle_cnt` by 1, second pulses `free_err` and leaves `idle_cnt` unchanged. Also, free the currently offered `alloc_addr` → `free_err`.
- Accept a grant of 5 while freeing 3 in the same cycle → `idle_cnt` unchanged, bit 5 set, bit 3 clear. Accept 5 while freeing 5 → `free_err`, bit 5 set.
- Assert `sys_rst` mid-scan with 200 slots used → all outputs return to reset values and the first grant after release is address 0.
